// File: rtl/mem_arb_pkg.sv
`default_nettype none
// =============================================================================
// Module   : mem_arb_pkg
// Purpose  : State encoding, access size codes and IO base shared by the
//            memory arbiter and its byte sequencer.
// Revision : 1.0 - initial release
// =============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [1:0]  SIZE_BYTE = 2'd0;
  localparam logic [1:0]  SIZE_HALF = 2'd1;
  localparam logic [1:0]  SIZE_WORD = 2'd2;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // The illegal size code 3 falls back to a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_n = 3'd1;
      SIZE_HALF: size_to_n = 3'd2;
      default:   size_to_n = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_seq.sv
`default_nettype none
// =============================================================================
// Module   : mem_byte_seq
// Purpose  : Byte counter, address increment, store lane select and load word
//            assembly for one word-sized memory access.
// Revision : 1.0 - initial release
// =============================================================================
module mem_byte_seq (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [2:0]  start_n,
  input  logic [2:0]  start_cnt,
  input  logic [31:0] start_wdata,
  input  logic        inc,
  input  logic        cap,
  input  logic [7:0]  cap_byte,
  output logic [2:0]  cnt,
  output logic [2:0]  n,
  output logic [31:0] base,
  output logic [31:0] addr,
  output logic [7:0]  wbyte,
  output logic [31:0] word
);

  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [1:0]  w_cap_lane;
  logic [1:0]  w_last_lane;

  // A read byte arrives two counts after it was addressed.
  assign w_cap_lane  = r_cnt[1:0] - 2'd2;
  assign w_last_lane = r_n[1:0] - 2'd1;

  assign cnt  = r_cnt;
  assign n    = r_n;
  assign base = r_base;
  assign addr = r_base + {29'd0, r_cnt};
  assign word = r_buf | ({24'd0, cap_byte} << {w_last_lane, 3'b000});

  always_comb begin
    case (r_cnt[1:0])
      2'd0:    wbyte = r_wdata[7:0];
      2'd1:    wbyte = r_wdata[15:8];
      2'd2:    wbyte = r_wdata[23:16];
      default: wbyte = r_wdata[31:24];
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt   <= 3'd0;
      r_n     <= 3'd0;
      r_base  <= 32'd0;
      r_wdata <= 32'd0;
      r_buf   <= 32'd0;
    end else if (en) begin
      if (start) begin
        r_cnt   <= start_cnt;
        r_n     <= start_n;
        r_base  <= start_addr;
        r_wdata <= start_wdata;
        r_buf   <= 32'd0;
      end else begin
        if (inc) r_cnt <= r_cnt + 3'd1;
        if (cap) r_buf <= r_buf | ({24'd0, cap_byte} << {w_cap_lane, 3'b000});
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the byte-wide RAM/IO port between fetch and load/store.
//            Define MEM_ARB_ROUND_ROBIN_EN for alternating tie arbitration.
// Revision : 1.0 - initial release
// =============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      r_state, w_state_n;
  logic        r_is_if, w_is_if_n;
  logic [31:0] w_mem_a_n;
  logic [7:0]  w_mem_dout_n;
  logic        w_mem_wr_n;
  logic        w_if_done_n, w_ls_done_n;
  logic [31:0] w_if_data_n, w_ls_rdata_n;

  logic        w_start, w_inc, w_cap;
  logic [31:0] w_start_addr, w_start_wdata;
  logic [2:0]  w_start_n, w_start_cnt;
  logic [2:0]  w_cnt, w_n;
  logic [31:0] w_base, w_addr, w_word;
  logic [7:0]  w_wbyte;

  logic        w_ls_ok, w_if_ok, w_gnt_ls, w_gnt_if;

  // Flush kills speculative requests but never a committed store.
  assign w_ls_ok = ls_req & (ls_wr | ~flush);
  assign w_if_ok = if_req & ~flush;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_ls, w_last_ls_n;
  assign w_gnt_ls = w_ls_ok & ~(w_if_ok & r_last_ls);
`else
  assign w_gnt_ls = w_ls_ok;
`endif
  assign w_gnt_if = w_if_ok & ~w_gnt_ls;

  mem_byte_seq u_seq (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en          (rdy_in),
    .start       (w_start),
    .start_addr  (w_start_addr),
    .start_n     (w_start_n),
    .start_cnt   (w_start_cnt),
    .start_wdata (w_start_wdata),
    .inc         (w_inc),
    .cap         (w_cap),
    .cap_byte    (mem_din),
    .cnt         (w_cnt),
    .n           (w_n),
    .base        (w_base),
    .addr        (w_addr),
    .wbyte       (w_wbyte),
    .word        (w_word)
  );

  always_comb begin
    w_state_n     = r_state;
    w_is_if_n     = r_is_if;
    w_mem_a_n     = mem_a;
    w_mem_dout_n  = mem_dout;
    w_mem_wr_n    = 1'b0;
    w_if_done_n   = 1'b0;
    w_ls_done_n   = 1'b0;
    w_if_data_n   = if_data;
    w_ls_rdata_n  = ls_rdata;
    w_start       = 1'b0;
    w_start_addr  = ls_addr;
    w_start_n     = size_to_n(ls_size);
    w_start_cnt   = 3'd1;
    w_start_wdata = ls_wdata;
    w_inc         = 1'b0;
    w_cap         = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_last_ls_n   = r_last_ls;
`endif
    case (r_state)
      ST_IDLE: begin
        // The accepting edge already issues byte 0, so the counter starts at 1.
        if (w_gnt_ls) begin
          w_start   = 1'b1;
          w_is_if_n = 1'b0;
          if (ls_wr) begin
            w_state_n = ST_WRITE;
            if ((ls_addr >= IO_BASE) && io_buffer_full) begin
              w_start_cnt = 3'd0;
              w_mem_a_n   = 32'd0;
            end else begin
              w_mem_a_n    = ls_addr;
              w_mem_dout_n = ls_wdata[7:0];
              w_mem_wr_n   = 1'b1;
            end
          end else begin
            w_state_n = ST_READ;
            w_mem_a_n = ls_addr;
          end
        end else if (w_gnt_if) begin
          w_start       = 1'b1;
          w_is_if_n     = 1'b1;
          w_state_n     = ST_READ;
          w_mem_a_n     = if_addr;
          w_start_addr  = if_addr;
          w_start_n     = 3'd4;
          w_start_wdata = 32'd0;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (w_gnt_ls || w_gnt_if) w_last_ls_n = w_gnt_ls;
`endif
      end
      ST_READ: begin
        if (flush) begin
          w_state_n = ST_IDLE;
          w_mem_a_n = 32'd0;
        end else begin
          w_inc = 1'b1;
          if (w_cnt < w_n) w_mem_a_n = w_addr;
          if ((w_cnt >= 3'd2) && (w_cnt <= w_n)) w_cap = 1'b1;
          if (w_cnt == (w_n + 3'd1)) begin
            w_state_n = ST_IDLE;
            w_mem_a_n = 32'd0;
            if (r_is_if) begin
              w_if_done_n = 1'b1;
              w_if_data_n = w_word;
            end else begin
              w_ls_done_n  = 1'b1;
              w_ls_rdata_n = w_word;
            end
          end
        end
      end
      ST_WRITE: begin
        if (w_cnt == w_n) begin
          w_state_n   = ST_IDLE;
          w_mem_a_n   = 32'd0;
          w_ls_done_n = 1'b1;
        end else if ((w_base >= IO_BASE) && io_buffer_full) begin
          w_mem_a_n = 32'd0;
        end else begin
          w_mem_a_n    = w_addr;
          w_mem_dout_n = w_wbyte;
          w_mem_wr_n   = 1'b1;
          w_inc        = 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_is_if  <= 1'b0;
      mem_a    <= 32'd0;
      mem_dout <= 8'd0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= 32'd0;
      ls_rdata <= 32'd0;
    end else if (!rdy_in) begin
      mem_wr <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_is_if  <= w_is_if_n;
      mem_a    <= w_mem_a_n;
      mem_dout <= w_mem_dout_n;
      mem_wr   <= w_mem_wr_n;
      if_done  <= w_if_done_n;
      ls_done  <= w_ls_done_n;
      if_data  <= w_if_data_n;
      ls_rdata <= w_ls_rdata_n;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to LSB so that fetch wins the first tie.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      r_last_ls <= 1'b1;
    else if (rdy_in) r_last_ls <= w_last_ls_n;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed vector bench for mem_arbiter with a byte RAM model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_wr = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [1:0]  ls_size = 2'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM: data appears the cycle after its address.
  logic [7:0] ram [0:4095];
  always @(posedge clk_in) begin
    if (mem_wr && (mem_a < 32'h0003_0000)) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];
  always @(negedge clk_in) if (mem_wr) wlog.push_back('{mem_a, mem_dout});

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input bit is_if, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input int flush_at, input int io_cyc,
                         output int lat, output logic [31:0] data, output int stall_bad);
    lat = -1;
    data = 32'hxxxx_xxxx;
    stall_bad = 0;
    @(negedge clk_in);
    wlog.delete();
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_wr = wr; ls_addr = addr; ls_size = size; ls_wdata = wdata;
    end
    io_buffer_full = (io_cyc > 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (c <= io_cyc && (mem_wr || mem_a != 32'd0)) stall_bad++;
      if (c == io_cyc) io_buffer_full = 1'b0;
      if (c == flush_at + 1) flush = 1'b0;
      if (flush_at > 0 && c == flush_at) begin
        flush = 1'b1;
        if (!wr) begin if_req = 1'b0; ls_req = 1'b0; end
      end
      if (is_if ? if_done : ls_done) begin
        lat = c;
        data = is_if ? if_data : ls_rdata;
        break;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; flush = 1'b0; io_buffer_full = 1'b0;
  endtask

  task automatic check_wlog(input string name, input logic [31:0] addr,
                            input logic [31:0] wdata, input int nbytes);
    logic [31:0] sh;
    check({name, "_nwrites"}, 32'(wlog.size()), 32'(nbytes));
    for (int k = 0; k < nbytes && k < wlog.size(); k++) begin
      sh = wdata >> (8 * k);
      check($sformatf("%s_byte%0d", name, k), {wlog[k].a[23:0], wlog[k].d},
            {addr[23:0] + 24'(k), sh[7:0]});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, sbad;
    logic [31:0] data;
    int          nd;
    logic [31:0] order [2];
    logic [31:0] exp_w0, exp_w1;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;

    //                is_if wr  addr          size  wdata          exp_data       lat
    vecs[0] = '{1'b1, 1'b0, 32'h100, 2'd2, 32'h0,          32'h0000_0513, 6};
    vecs[1] = '{1'b0, 1'b1, 32'h200, 2'd2, 32'hDEAD_BEEF,  32'h0,         5};
    vecs[2] = '{1'b0, 1'b0, 32'h202, 2'd1, 32'h0,          32'h0000_DEAD, 4};
    vecs[3] = '{1'b0, 1'b0, 32'h203, 2'd0, 32'h0,          32'h0000_00DE, 3};
    vecs[4] = '{1'b0, 1'b0, 32'h200, 2'd2, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[5] = '{1'b0, 1'b1, 32'h201, 2'd0, 32'hFFFF_FF77,  32'h0,         2};
    vecs[6] = '{1'b0, 1'b0, 32'h200, 2'd2, 32'h0,          32'hDEAD_77EF, 6};
    vecs[7] = '{1'b0, 1'b1, 32'h300, 2'd1, 32'hAAAA_1234,  32'h0,         3};
    vecs[8] = '{1'b0, 1'b0, 32'h300, 2'd2, 32'h0,          32'h0000_1234, 6};
    vecs[9] = '{1'b1, 1'b0, 32'h200, 2'd2, 32'h0,          32'hDEAD_77EF, 6};

    repeat (2) @(negedge clk_in);
    check("reset_mem_a", mem_a, 32'd0);
    check("reset_ctrl", {21'd0, mem_wr, if_done, ls_done, mem_dout}, 32'd0);
    check("reset_if_data", if_data, 32'd0);
    check("reset_ls_rdata", ls_rdata, 32'd0);
    rst_in = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].is_if, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
              0, 0, lat, data, sbad);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].wr)
        check_wlog($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata,
                   1 << vecs[i].size);
      else
        check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      @(negedge clk_in);
      check($sformatf("vec%0d_done_single", i), {30'd0, if_done, ls_done}, 32'd0);
    end

    // Asynchronous reset in the middle of a word load.
    @(negedge clk_in);
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h200; ls_size = 2'd2;
    repeat (3) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_mem_a", mem_a, 32'd0);
    check("async_rst_rdata", {if_data | ls_rdata}, 32'd0);
    ls_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    run_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, 0, 0, lat, data, sbad);
    check("post_rst_fetch_lat", 32'(lat), 32'd6);
    check("post_rst_fetch_data", data, 32'h0000_0513);

    // Two back-to-back ties straight after reset.
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in); rst_in = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h100; ls_size = 2'd0;
    order[0] = 32'd2; order[1] = 32'd2; nd = 0;
    for (int c = 0; c < 60 && nd < 2; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (if_done || ls_done) begin
        order[nd] = {31'd0, ls_done};
        nd++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_w0 = 32'd0; exp_w1 = 32'd1;
`else
    exp_w0 = 32'd1; exp_w1 = 32'd1;
`endif
    check("tie1_ls_won", order[0], exp_w0);
    check("tie2_ls_won", order[1], exp_w1);

    // Flush two cycles into a fetch: no completion, then a clean fetch.
    run_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, 2, 0, lat, data, sbad);
    check("flush_fetch_no_done", 32'(lat), 32'hFFFF_FFFF);
    run_txn(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, 0, 0, lat, data, sbad);
    check("after_flush_fetch_lat", 32'(lat), 32'd6);
    check("after_flush_fetch_data", data, 32'h0000_0513);

    // Flush during a word store must not disturb it.
    run_txn(1'b0, 1'b1, 32'h400, 2'd2, 32'hCAFE_F00D, 2, 0, lat, data, sbad);
    check("flush_store_lat", 32'(lat), 32'd5);
    check_wlog("flush_store", 32'h400, 32'hCAFE_F00D, 4);
    run_txn(1'b0, 1'b0, 32'h400, 2'd2, 32'h0, 0, 0, lat, data, sbad);
    check("flush_store_readback", data, 32'hCAFE_F00D);

    // IO byte store stalled three cycles by a full UART buffer.
    run_txn(1'b0, 1'b1, 32'h0003_0000, 2'd0, 32'h0000_0041, 0, 3, lat, data, sbad);
    check("io_stall_lat", 32'(lat), 32'd5);
    check("io_stall_bus_idle", 32'(sbad), 32'd0);
    check_wlog("io_stall", 32'h0003_0000, 32'h0000_0041, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM/IO port of `riscv_top` between instruction fetch and the load/store buffer. Accepts one word-sized request at a time, serialises it into byte accesses on the memory bus, reassembles read data, and returns a one-cycle completion pulse to the winning requester. It sits inside the CPU core between the fetch/LSB units and the `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

## Interface
- `IO_BASE`, 32'h0003_0000, addresses at or above this are memory-mapped I/O.
- `clk_in`  in  1  core clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `rdy_in`  in  1  global enable; low freezes all state.
- `flush`  in  1  pipeline clear (mispredict); aborts fetch and loads.
- `if_req`  in  1  fetch request, held until `if_done`.
- `if_addr`  in  32  fetch byte address.
- `if_done`  out  1  one-cycle completion pulse.
- `if_data`  out  32  instruction word, valid with `if_done`.
- `ls_req`  in  1  load/store request, held until `ls_done`.
- `ls_wr`  in  1  1 = store, 0 = load.
- `ls_addr`  in  32  byte address.
- `ls_size`  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B; 3 is illegal.
- `ls_wdata`  in  32  store data, little-endian.
- `ls_done`  out  1  one-cycle completion pulse.
- `ls_rdata`  out  32  load data, zero-extended, valid with `ls_done`.
- `mem_din`  in  8  RAM/IO read byte.
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART TX buffer full.

## Operation
- States: IDLE, READ, WRITE. A request is accepted only in IDLE. Once accepted, it runs to completion unless a flush aborts it.
- Arbitration in IDLE: LSB wins over fetch when both are requesting. See Configuration for the alternative policy.
- A byte counter `cnt` counts 0..N-1, where N = 4 for fetch and N = 1 << `ls_size` for load/store.
- Byte k is at address + k and occupies bits [8k+7:8k] of the word.
- READ: drive `mem_a` = addr + k for k = 0..N-1 with `mem_wr` = 0. Capture `mem_din` one cycle after each address. After the last byte, pulse done and return to IDLE.
- WRITE: drive `mem_a` = addr + k, `mem_dout` = byte k, `mem_wr` = 1. After the last byte, pulse done and return to IDLE.
- IO write stall: if addr ≥ `IO_BASE` and `io_buffer_full` = 1, the next byte is not issued. During the stall, `mem_wr` = 0 and `mem_a` = 0, and `cnt` holds.
- `flush` = 1:
  - A fetch or load in progress returns to IDLE next cycle with no done pulse.
  - A store in progress is unaffected. Stores are already committed.
  - A flush in IDLE blocks acceptance of fetch and load requests that cycle.
- `rdy_in` = 0: state, counter and outputs hold, except `mem_wr`, which is forced to 0.
- Reset values: state IDLE, `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0, `if_done` = 0, `ls_done` = 0, `if_data` = 0, `ls_rdata` = 0. Reset mid-transaction discards it.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle T:
  - First bus address is visible at T+1.
  - Bytes are addressed at T+1..T+N and captured at T+2..T+N+1.
- Read done pulses at T+N+2. A 4-byte fetch therefore takes 6 cycles from sample to `if_done`.
- Write: bytes are on the bus at T+1..T+N. Done pulses at T+N+1.
- Each IO stall cycle adds one cycle.
- After done, the state is IDLE. The requester deasserts `req` in the done cycle, so the earliest re-accept is the cycle after done.
- Back-to-back accesses: the bus is idle (`mem_wr` = 0) for at least one cycle between transactions.

## Configuration
- Macro `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: a 1-bit last-grant register is kept. On a simultaneous request, the requester not granted last time wins. Reset value: last grant = LSB, so fetch wins the first tie.
  - Undefined: fixed LSB priority, and no last-grant register exists.

## Structure
- Shared package `mem_arb_pkg`: state encoding (IDLE/READ/WRITE), size codes, `IO_BASE` default.
- One sub-module, `mem_byte_seq`: the counter, address increment and byte lane select/assemble. The arbiter FSM in `mem_arbiter` drives it.

## Test plan
- Fetch only, `if_addr` = 0x100, RAM[0x100..0x103] = 13 05 00 00 -> `if_done` at T+6, `if_data` = 0x00000513.
- Word store then load: store 0xDEADBEEF to 0x200 -> bus writes EF, BE, AD, DE at 0x200..0x203 and `ls_done` at T+5. A subsequent 2-byte load from 0x202 -> `ls_rdata` = 0x0000DEAD.
- Simultaneous `if_req` and `ls_req`:
  - Without the macro, the LSB wins both ties.
  - With the macro, fetch wins the first tie and LSB wins the next.
- Byte store of 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles -> `mem_wr` stays 0 during the stall, then one write of 0x41 at 0x30000, and `ls_done` 3 cycles later than nominal.
- `flush` two cycles into a fetch -> no `if_done`, IDLE next cycle. `flush` during a word store -> all 4 bytes are written and `ls_done` pulses.
- `rst_in` asserted mid-load, asynchronously -> outputs go to 0 immediately. After release, the next fetch completes normally.
